feature_quant_packer: RTL and testbench
=======================================

# feature_quant_packer

Upstream feeder for the 2×2 pixel-shuffle stage of the decoder's upsampling path. It accepts a stream of signed 16-bit convolution accumulators and requantises each one to an unsigned 8-bit pixel. It assembles 16 pixels into one 128-bit channel-major frame (4 channels × 2×2) and hands the frame downstream with a valid/ready handshake. A ping-pong arrangement (one assembly register plus one output register) lets the next frame be collected while the current one waits for acceptance.

## Interface
Parameters:
- SHIFT, default 4: right-shift applied in requantisation, range 0..15.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  16  signed accumulator sample.
- in_last  in  1  marks the final (16th) sample of a frame.
- out_valid  out  1  out_data_flat holds a complete frame.
- out_ready  in  1  downstream accepts the frame. The top level drives the shuffle stage's start from out_valid & out_ready.
- out_data_flat  out  128  packed frame; byte k = bits [8k+7:8k].
- frame_err  out  1  one-cycle pulse on a framing error.

## Operation
- Accept: a sample is accepted in any cycle with in_valid & in_ready.
- Requantise (combinational, applied before storing):
  - r = SHIFT>0 ? 1<<(SHIFT-1) : 0.
  - t = (sign-extend17(in_data) + r) >>> SHIFT, evaluated in 17 bits (no overflow).
  - pixel = clamp(t, 0, 255).
- Index counter cnt runs 0..15. The k-th accepted sample of a frame is written to assembly byte k.
  - Byte order is k = c·4 + h·2 + w: channel-major, then row, then column.
- Frame completion: accepting at cnt==15 completes the frame and resets cnt to 0. in_last is irrelevant to completion.
  - If in_last==0 at completion, frame_err pulses and the frame is still kept.
- Short frame: in_last==1 accepted at cnt<15 causes:
  - frame_err pulses;
  - the partial frame is discarded;
  - cnt resets to 0;
  - no out_valid results.
- Output register is "free" in a cycle if out_valid==0, or out_valid & out_ready in that cycle.
- On completion in cycle T:
  - If the output register is free: the full frame, including the byte just accepted, loads into out_data_flat at the end of T.
  - Otherwise: asm_full is set.
- While asm_full==1: in_ready=0. In the first cycle the output register is free, the assembly frame transfers to the output register and asm_full clears.
- out_valid:
  - set on any load into the output register;
  - cleared on out_valid & out_ready when no load occurs in the same cycle;
  - stays 1 when a load coincides with a handshake (back-to-back frames).
- out_data_flat is stable whenever out_valid==1 until the handshake completes.
- in_ready = !asm_full & !rst.

## Timing
- Reset values (the cycle after rst is sampled high):
  - cnt=0, asm_full=0, out_valid=0, out_data_flat=0, frame_err=0.
  - in_ready=0 while rst is high; it is 1 in the first cycle after rst deasserts.
- Latency: 16th sample accepted in cycle T → out_valid=1 in T+1, if the output register was free in T.
- Throughput: one sample per cycle sustained when out_ready is held at 1. There are no bubbles between frames.
- Backpressure: with out_ready=0, the block accepts one further full frame (16 samples), then drops in_ready. in_ready rises again in the cycle after the first out_ready handshake.
- frame_err is registered: it is high in the cycle after the offending accept, for exactly one cycle.
- Reset mid-frame or mid-hold: all state is discarded; no partial frame is ever presented.
- in_data and in_last are ignored when in_valid & in_ready is false.

## Test plan
- Ramp with SHIFT=4, out_ready=1: 16 samples in_data = 16·k + 8, k=0..15, with in_last on k=15.
  - Required: out_valid one cycle after the 16th accept; byte k = k+1 (rounding of +8 then >>>4); frame_err never asserts.
- Saturation: samples −100, 4095, 4096, 32767, −32768, 0 in a frame.
  - Required bytes: 0, 255, 255, 255, 0, 0.
- Backpressure: with out_ready=0, stream 40 samples with in_valid held high.
  - Required: exactly 32 accepted; in_ready=0 from the cycle after the 32nd accept.
  - On a 1-cycle out_ready pulse: frame 0 leaves, frame 1 appears in out_data_flat the next cycle, and in_ready=1.
- Back-to-back: out_ready=1, 48 consecutive samples.
  - Required: in_ready is never low; out_valid pulses at T+1 after accepts 16, 32 and 48; the frames are correct.
- Framing: in_last on the 10th sample, then a 16-sample frame with no in_last.
  - Required: frame_err pulses twice; only the second frame is output.
- Reset after 7 accepted samples, then a fresh 16-sample frame.
  - Required: out_valid=0 and out_data_flat=0 after reset; the next output frame contains only post-reset samples.

Source files
------------

// File: rtl/feature_quant_packer.sv
// feature_quant_packer: requantises signed 16-bit accumulators to 8-bit pixels and packs
// 16 of them into a channel-major 128-bit frame behind a ping-pong output register.
module feature_quant_packer #(
    parameter int SHIFT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data_flat,
    output logic          frame_err
);
    localparam logic [16:0] RND = (17'(1) << SHIFT) >> 1;

    logic [3:0]         cnt;
    logic [127:0]       asm_q, asm_d;
    logic               asm_full, acc, done, free;
    logic signed [16:0] sum, t;
    logic [7:0]         pixel;

    assign in_ready = !asm_full & !rst;
    assign acc      = in_valid & in_ready;
    assign done     = acc & (cnt == 4'd15);
    assign free     = !out_valid | out_ready;

    // asm_d is the assembly frame with the current sample merged in, so a completing
    // frame can go straight to the output register without waiting a cycle
    always_comb begin
        sum   = $signed({in_data[15], in_data}) + $signed(RND);
        t     = sum >>> SHIFT;
        pixel = t[16] ? 8'd0 : (|t[15:8]) ? 8'hff : t[7:0];
        asm_d = asm_q;
        asm_d[{cnt, 3'b000} +: 8] = pixel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            asm_q         <= '0;
            asm_full      <= 1'b0;
            out_valid     <= 1'b0;
            out_data_flat <= '0;
            frame_err     <= 1'b0;
        end else begin
            frame_err <= acc & (in_last ^ (cnt == 4'd15));
            if (acc) begin
                cnt   <= (done | in_last) ? 4'd0 : cnt + 4'd1;
                asm_q <= asm_d;
            end
            if (free & (done | asm_full)) begin
                out_data_flat <= asm_full ? asm_q : asm_d;
                out_valid     <= 1'b1;
                asm_full      <= 1'b0;
            end else begin
                if (done) asm_full <= 1'b1;
                if (out_ready) out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_feature_quant_packer.sv
// tb_feature_quant_packer: directed scenarios for the quantising frame packer.
module tb_feature_quant_packer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data_flat;
    logic         frame_err;

    int passed = 0;
    int total = 0;

    feature_quant_packer #(.SHIFT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data_flat(out_data_flat), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // byte k = base + k; inputs 16*(base-1+k)+8 round to exactly this
    function automatic logic [127:0] ramp_frame(input int base);
        logic [127:0] f = '0;
        for (int k = 0; k < 16; k++) f[8*k +: 8] = 8'(base + k);
        return f;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (out_data_flat !== 128'd0) $display("FAIL reset_out_data got %h want 0", out_data_flat); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", frame_err); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_in_rst got %b want 0", in_ready); else passed++;
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready_after got %b want 1", in_ready); else passed++;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        logic rdy_ok = 1'b1, err_seen = 1'b0, early_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; in_data = 16'(16*k + 8); in_last = (k == 15);
            rdy_ok &= in_ready;
            early_valid |= out_valid;
            step();
            err_seen |= frame_err;
        end
        in_valid = 1'b0; in_last = 1'b0;
        total++; if (!rdy_ok || early_valid) $display("FAIL ramp_ready_valid rdy_ok=%b early_valid=%b want 1/0", rdy_ok, early_valid); else passed++;
        total++; if (out_valid !== 1'b1) $display("FAIL ramp_latency out_valid got %b want 1", out_valid); else passed++;
        total++; if (out_data_flat !== ramp_frame(1)) $display("FAIL ramp_data got %h want %h", out_data_flat, ramp_frame(1)); else passed++;
        total++; if (err_seen !== 1'b0) $display("FAIL ramp_frame_err got %b want 0", err_seen); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL ramp_handshake_clear got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_saturation();
        logic [15:0] vals [6] = '{16'hff9c, 16'd4095, 16'd4096, 16'd32767, 16'h8000, 16'd0};
        logic [127:0] exp = 128'h0000_ffff_ff00;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; in_data = (k < 6) ? vals[k] : 16'd0; in_last = (k == 15);
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data_flat !== exp) $display("FAIL saturation valid=%b got %h want %h", out_valid, out_data_flat, exp); else passed++;
        step();
    endtask

    task automatic test_backpressure();
        int acc = 0, acc32_cyc = -1, low_cyc = -1;
        logic err_seen = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            in_valid = 1'b1; in_data = 16'(16*acc + 8); in_last = (acc % 16 == 15);
            if (!in_ready && low_cyc < 0) low_cyc = c;
            if (in_ready) begin
                acc++;
                if (acc == 32) acc32_cyc = c;
            end
            step();
            err_seen |= frame_err;
        end
        in_valid = 1'b0; in_last = 1'b0;
        total++; if (acc !== 32) $display("FAIL bp_accept_count got %0d want 32", acc); else passed++;
        total++; if (low_cyc !== acc32_cyc + 1) $display("FAIL bp_ready_drop cycle got %0d want %0d", low_cyc, acc32_cyc + 1); else passed++;
        total++; if (out_valid !== 1'b1 || out_data_flat !== ramp_frame(1)) $display("FAIL bp_frame0 valid=%b got %h want %h", out_valid, out_data_flat, ramp_frame(1)); else passed++;
        total++; if (err_seen !== 1'b0) $display("FAIL bp_frame_err got %b want 0", err_seen); else passed++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data_flat !== ramp_frame(17)) $display("FAIL bp_frame1 valid=%b got %h want %h", out_valid, out_data_flat, ramp_frame(17)); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_rise got %b want 1", in_ready); else passed++;
        step();
        total++; if (out_valid !== 1'b1 || out_data_flat !== ramp_frame(17)) $display("FAIL bp_hold valid=%b got %h want %h", out_valid, out_data_flat, ramp_frame(17)); else passed++;
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        logic rdy_ok = 1'b1, vld_ok = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 48; i++) begin
            in_valid = 1'b1; in_data = 16'(16*i + 8); in_last = (i % 16 == 15);
            rdy_ok &= in_ready;
            step();
            vld_ok &= (out_valid === (i % 16 == 15));
            if (i % 16 == 15) begin
                total++;
                if (out_data_flat !== ramp_frame(i - 14)) $display("FAIL b2b_frame%0d got %h want %h", i / 16, out_data_flat, ramp_frame(i - 14)); else passed++;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        total++; if (!rdy_ok) $display("FAIL b2b_in_ready got low want always 1"); else passed++;
        total++; if (!vld_ok) $display("FAIL b2b_out_valid_pattern got wrong want pulses after 16/32/48"); else passed++;
        step();
    endtask

    task automatic test_framing();
        logic vld_seen = 1'b0, err_seen = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_data = 16'(16*(k + 60) + 8); in_last = (k == 9);
            step();
            vld_seen |= out_valid;
        end
        in_valid = 1'b0; in_last = 1'b0;
        total++; if (frame_err !== 1'b1) $display("FAIL short_frame_err got %b want 1", frame_err); else passed++;
        step();
        total++; if (frame_err !== 1'b0) $display("FAIL short_frame_err_width got %b want 0", frame_err); else passed++;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; in_data = 16'(16*(k + 100) + 8); in_last = 1'b0;
            vld_seen |= out_valid;
            err_seen |= frame_err;
            step();
        end
        in_valid = 1'b0;
        total++; if (vld_seen !== 1'b0 || err_seen !== 1'b0) $display("FAIL short_discard out_valid=%b frame_err=%b want 0/0", vld_seen, err_seen); else passed++;
        total++; if (frame_err !== 1'b1) $display("FAIL nolast_frame_err got %b want 1", frame_err); else passed++;
        total++; if (out_valid !== 1'b1 || out_data_flat !== ramp_frame(101)) $display("FAIL nolast_frame valid=%b got %h want %h", out_valid, out_data_flat, ramp_frame(101)); else passed++;
        step();
        total++; if (frame_err !== 1'b0) $display("FAIL nolast_frame_err_width got %b want 0", frame_err); else passed++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1; in_data = 16'd3200; in_last = 1'b0;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0 || out_data_flat !== 128'd0) $display("FAIL midreset_clear valid=%b got %h want 0", out_valid, out_data_flat); else passed++;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; in_data = 16'(16*(k + 50) + 8); in_last = (k == 15);
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data_flat !== ramp_frame(51)) $display("FAIL midreset_frame valid=%b got %h want %h", out_valid, out_data_flat, ramp_frame(51)); else passed++;
        step();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_framing();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
